// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - kp_state_t   : scanner FSM states (IDLE, DEBOUNCE, PRESSED, RELEASE)
//   - KEY_W        : width of the emitted key code
//   - COL_RESET    : column strobe pattern after reset (column 0 driven low)
//   - row_priority : active-low row vector -> index of the lowest low row
//   - col_index    : one-hot active-low column vector -> column index
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Lowest row index wins when several rows are pulled low at once.
    // Returns 0 when no row is low; callers qualify with rs_n != 4'hF.
    function automatic logic [1:0] row_priority(input logic [3:0] row_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Position of the (single) zero bit in an active-low one-hot strobe.
    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_decoder_if
// Bundles the keypad matrix lines and the decoded key outputs.
//   row_n     : keypad row returns, active-low (keypad -> scanner)
//   col_n     : column strobes, one-hot active-low (scanner -> keypad)
//   key_code  : last accepted key, 4*row + col
//   key_valid : one-cycle pulse whenever key_code is (re)issued
//   key_down  : high while an accepted key is held
// Modports:
//   master : the scanner side (drives strobes and key outputs)
//   slave  : the keypad / consumer side
// -----------------------------------------------------------------------------
interface keypad_scan_decoder_if;
    import keypad_pkg::*;

    logic [3:0]       row_n;
    logic [3:0]       col_n;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_down;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_down
    );

endinterface

// File: rtl/keypad_scan_decoder_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running divider 0..SCAN_DIV-1; tick is high for the one clk cycle in
// which the divider sits at its terminal count (i.e. the cycle it wraps).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (divider returns to 0)
//   tick  : one-cycle scan tick
// -----------------------------------------------------------------------------
module scan_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/keypad_scan_decoder.sv
// -----------------------------------------------------------------------------
// keypad_scan_decoder
// Scans a 4x4 matrix keypad with one-hot active-low column strobes, reads the
// row returns through a 2-flop synchronizer, debounces press and release on
// scan ticks and reports the accepted key as code = 4*row_idx + col_idx.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scan_decoder_if.master (row_n in; col_n, key_code,
//           key_valid, key_down out)
// Parameters:
//   SCAN_DIV     : clk cycles per scan tick (>= 4)
//   DEBOUNCE_CNT : agreeing tick samples to accept a press or release (>= 1)
//   REPEAT_TICKS : held ticks between auto-repeat pulses
// Build option:
//   KEY_REPEAT_EN : when defined, a held key re-pulses key_valid every
//                   REPEAT_TICKS ticks; when undefined exactly one key_valid
//                   is issued per debounced press and no repeat counter exists.
// -----------------------------------------------------------------------------
module keypad_scan_decoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_scan_decoder_if.master kp
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    // SCAN_DIV below 4 would let a tick sample rows before the synchronizer
    // has caught up with a column change. Unsupported settings simply park
    // the scanner on column 0 rather than produce bogus keys.
    localparam bit CFG_OK = (SCAN_DIV >= 4) && (DEBOUNCE_CNT >= 1) && (REPEAT_TICKS >= 1);

    // ---------------------------------------------------------------- tick
    logic tick_raw;
    logic tick;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_raw)
    );

    assign tick = tick_raw & CFG_OK;

    // -------------------------------------------------------- synchronizer
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] rs_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 4'hF;
            sync2_reg <= 4'hF;
        end else begin
            sync1_reg <= kp.row_n;
            sync2_reg <= sync1_reg;
        end
    end

    assign rs_n = sync2_reg;

    // ----------------------------------------------------------------- FSM
    kp_state_t        state_reg, state_next;
    logic [3:0]       col_reg, col_next;
    logic [3:0]       cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [KEY_W-1:0] code_reg, code_next;
    logic             down_reg, down_next;
    logic             valid_reg;
    logic             accept_pulse;
    logic             rep_fire;

    logic             any_low;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       col_rot;

    assign any_low = (rs_n != 4'hF);
    assign row_idx = row_priority(rs_n);
    assign col_idx = col_index(col_reg);
    assign col_rot = {col_reg[2:0], col_reg[3]};
    // Saturating increment keeps the counter in range whatever the width.
    assign cnt_inc = (cnt_reg == CNT_DONE) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            col_reg   <= COL_RESET;
            cand_reg  <= '0;
            cnt_reg   <= '0;
            code_reg  <= '0;
            down_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            code_reg  <= code_next;
            down_reg  <= down_next;
            valid_reg <= accept_pulse | rep_fire;
        end
    end

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        cand_next    = cand_reg;
        cnt_next     = cnt_reg;
        code_next    = code_reg;
        down_next    = down_reg;
        accept_pulse = 1'b0;

        if (tick) begin
            unique case (state_reg)
                IDLE: begin
                    if (any_low) begin
                        // Freeze on this column and start qualifying the press.
                        cand_next = {row_idx, col_idx};
                        if (DEBOUNCE_CNT == 1) begin
                            code_next    = {row_idx, col_idx};
                            accept_pulse = 1'b1;
                            down_next    = 1'b1;
                            cnt_next     = '0;
                            state_next   = PRESSED;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col_rot;
                    end
                end

                DEBOUNCE: begin
                    if (any_low && (row_idx == cand_reg[3:2])) begin
                        if (cnt_inc >= CNT_DONE) begin
                            code_next    = cand_reg;
                            accept_pulse = 1'b1;
                            down_next    = 1'b1;
                            cnt_next     = '0;
                            state_next   = PRESSED;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        // Bounce or a different row: give up and move on to
                        // the next column so a stuck row cannot starve others.
                        cnt_next   = '0;
                        col_next   = col_rot;
                        state_next = IDLE;
                    end
                end

                PRESSED: begin
                    if (!any_low) begin
                        if (DEBOUNCE_CNT == 1) begin
                            down_next  = 1'b0;
                            cnt_next   = '0;
                            col_next   = col_rot;
                            state_next = IDLE;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = RELEASE;
                        end
                    end
                end

                RELEASE: begin
                    if (!any_low) begin
                        if (cnt_inc >= CNT_DONE) begin
                            down_next  = 1'b0;
                            cnt_next   = '0;
                            col_next   = col_rot;
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        // Release bounce: key is still held, no new key_valid.
                        cnt_next   = '0;
                        state_next = PRESSED;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // --------------------------------------------------------- auto-repeat
`ifdef KEY_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_TICKS);

    logic [REP_W-1:0] rep_reg, rep_next;
    logic [REP_W-1:0] rep_inc;
    logic             enter_pressed;

    assign enter_pressed = (state_next == PRESSED) && (state_reg != PRESSED);
    assign rep_inc       = rep_reg + REP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_reg <= '0;
        end else begin
            rep_reg <= rep_next;
        end
    end

    always_comb begin
        rep_next = rep_reg;
        rep_fire = 1'b0;
        if (enter_pressed) begin
            rep_next = '0;
        end else if (tick && (state_reg == PRESSED) && any_low) begin
            if (rep_inc >= REP_DONE) begin
                rep_fire = 1'b1;
                rep_next = '0;
            end else begin
                rep_next = rep_inc;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // ------------------------------------------------------------- outputs
    assign kp.col_n     = col_reg;
    assign kp.key_code  = code_reg;
    assign kp.key_valid = valid_reg;
    assign kp.key_down  = down_reg;

endmodule
